// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner and its consumers.
//   - FSM state encodings used by keypad_scanner.
//   - KEY_* codes (col_idx*4 + row_idx), used by vending_machine to decode key_code.
//   - col_drive(): column index to active-low one-hot column drive.
package keypad_pkg;

  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  // Column c is driven by pulling shift_col[3-c] low (c=0 -> 4'b0111).
  function automatic logic [3:0] col_drive(input logic [1:0] c);
    return ~(4'b1000 >> c);
  endfunction

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// row_sync: 4-bit two-flop synchronizer for the asynchronous keypad row lines.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset; both stages go to 4'b1111 (no row low)
//   row    in   raw keypad rows, active-low, asynchronous
//   row_s  out  synchronized rows
module row_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] row_s
);

  logic [3:0] row_meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta <= 4'b1111;
      row_s    <= 4'b1111;
    end else begin
      row_meta <= row;
      row_s    <= row_meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 keypad column by column and emits one debounced
// event per key press.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   row        in   keypad rows, active-low, asynchronous
//   shift_col  out  column drive, active-low one-hot
//   key_valid  out  one-cycle pulse when a debounced press is accepted
//   key_code   out  col_idx*4 + row_idx of the last accepted key, held between pulses
//   key_held   out  high from acceptance until debounced release
//
// state    | meaning
// ---------+----------------------------------------------------------
// SCAN     | rotating columns, looking for any low row at each sample
// DEBOUNCE | column frozen, counting consecutive low samples of cand row
// HELD     | key accepted, column frozen, waiting for cand row to go high
// RELEASE  | column frozen, counting consecutive high samples of cand row
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] shift_col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DBC_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DBC_W-1:0] DBC_DONE = DBC_W'(DEBOUNCE_SCANS);
  localparam logic [DBC_W-1:0] DBC_ONE  = DBC_W'(1);

  logic [3:0]       row_s;
  logic [1:0]       state, state_n;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic [1:0]       cand_col, cand_row;
  logic [DBC_W-1:0] dbc, dbc_n, dbc_inc;
  logic             sample, any_low, cand_low, dbc_hit;
  logic [1:0]       low_row;
  logic [3:0]       accept_code;
  logic             accept, release_done, advance, latch_cand;

  row_sync u_row_sync (
    .clk   (clk),
    .reset (reset),
    .row   (row),
    .row_s (row_s)
  );

  assign sample   = (div_cnt == DIV_LAST);
  assign any_low  = ~&row_s;
  assign cand_low = ~row_s[2'd3 - cand_row];
  assign dbc_inc  = (dbc < DBC_DONE) ? dbc + DBC_ONE : dbc;
  assign dbc_hit  = (dbc_inc == DBC_DONE);

  // Lowest row index wins when several rows are low; row_idx r is row_s[3-r].
  always_comb begin
    low_row = 2'd3;
    if      (!row_s[3]) low_row = 2'd0;
    else if (!row_s[2]) low_row = 2'd1;
    else if (!row_s[1]) low_row = 2'd2;
  end

  // With single-sample debounce the accept happens straight from SCAN, before
  // the candidate registers have been loaded.
  assign accept_code = (state == SCAN) ? {col_idx, low_row} : {cand_col, cand_row};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= SCAN;
    else       state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    if (sample) begin
      case (state)
        SCAN:     if (any_low) state_n = (DEBOUNCE_SCANS == 1) ? HELD : DEBOUNCE;
        DEBOUNCE: if (!cand_low) state_n = SCAN;
                  else if (dbc_hit) state_n = HELD;
        HELD:     if (!cand_low) state_n = (DEBOUNCE_SCANS == 1) ? SCAN : RELEASE;
        RELEASE:  if (cand_low) state_n = HELD;
                  else if (dbc_hit) state_n = SCAN;
        default:  state_n = SCAN;
      endcase
    end
  end

  // Control outputs of the FSM
  always_comb begin
    accept       = 1'b0;
    release_done = 1'b0;
    advance      = 1'b0;
    latch_cand   = 1'b0;
    dbc_n        = dbc;
    if (sample) begin
      case (state)
        SCAN: begin
          if (any_low) begin
            latch_cand = 1'b1;
            dbc_n      = DBC_ONE;
            accept     = (DEBOUNCE_SCANS == 1);
          end else begin
            advance = 1'b1;
          end
        end
        DEBOUNCE: begin
          if (cand_low) begin
            dbc_n  = dbc_inc;
            accept = dbc_hit;
          end else begin
            dbc_n   = '0;
            advance = 1'b1;
          end
        end
        HELD: begin
          if (!cand_low) begin
            if (DEBOUNCE_SCANS == 1) begin
              dbc_n        = '0;
              release_done = 1'b1;
              advance      = 1'b1;
            end else begin
              dbc_n = DBC_ONE;
            end
          end
        end
        RELEASE: begin
          if (!cand_low) begin
            dbc_n = dbc_inc;
            if (dbc_hit) begin
              dbc_n        = '0;
              release_done = 1'b1;
              advance      = 1'b1;
            end
          end else begin
            dbc_n = '0;
          end
        end
        default: dbc_n = '0;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt   <= '0;
      col_idx   <= 2'd0;
      cand_col  <= 2'd0;
      cand_row  <= 2'd0;
      dbc       <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      key_held  <= 1'b0;
    end else begin
      div_cnt   <= sample ? '0 : div_cnt + 1'b1;
      if (advance) col_idx <= col_idx + 2'd1;
      if (latch_cand) begin
        cand_col <= col_idx;
        cand_row <= low_row;
      end
      dbc       <= dbc_n;
      key_valid <= accept;
      if (accept) begin
        key_code <= accept_code;
        key_held <= 1'b1;
      end else if (release_done) begin
        key_held <= 1'b0;
      end
    end
  end

  assign shift_col = col_drive(col_idx);

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row;
  logic [3:0]  shift_col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;

  logic [15:0] key_down;
  int          n_checks = 0;
  int          n_errors = 0;
  int          pulse_cnt = 0;
  int          onehot_bad = 0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .shift_col (shift_col),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  // Keypad model: a pressed key (c,r) pulls row[3-r] low only while column c is driven.
  always_comb begin
    row = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (key_down[c*4+r] && !shift_col[3-c]) row[3-r] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid) pulse_cnt++;
    assert ($countones(~shift_col) == 1) else onehot_bad++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_col(input logic [3:0] v, output int n);
    n = 0;
    while (shift_col == v && n < 50) begin @(posedge clk); #1; n++; end
    while (shift_col != v && n < 50) begin @(posedge clk); #1; n++; end
  endtask

  task automatic wait_change(output int n);
    logic [3:0] prev;
    prev = shift_col;
    n = 0;
    while (shift_col == prev && n < 20) begin @(posedge clk); #1; n++; end
  endtask

  typedef struct {
    logic [15:0] mask;
    logic [3:0]  code;
    logic [3:0]  col;
    logic [3:0]  nxt;
    int          hold;
  } vec_t;

  vec_t       vecs[5];
  logic [3:0] rot[4];

  initial begin
    int n, p0, bad;

    // {pressed keys, code, frozen shift_col, shift_col after release, hold cycles}
    vecs[0] = '{16'h0001, 4'h0, 4'b0111, 4'b1011, 40};   // c0/r0
    vecs[1] = '{16'h0200, 4'h9, 4'b1101, 4'b1110, 100};  // c2/r1
    vecs[2] = '{16'h00A0, 4'h5, 4'b1011, 4'b1101, 40};   // c1 r1+r3
    vecs[3] = '{16'h8000, 4'hF, 4'b1110, 4'b0111, 40};   // c3/r3
    vecs[4] = '{16'h0040, 4'h6, 4'b1011, 4'b1101, 40};   // c1/r2
    rot[0] = 4'b1011; rot[1] = 4'b1101; rot[2] = 4'b1110; rot[3] = 4'b0111;

    reset = 1'b1;
    key_down = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_shift_col", shift_col, 4'b0111);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_code", key_code, 4'h0);
    check("rst_key_held", key_held, 1'b0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("div_first_dwell", shift_col, 4'b0111);
    @(posedge clk);
    #1;
    check("div_first_adv", shift_col, 4'b1011);

    for (int i = 0; i < 5; i++) begin
      p0 = pulse_cnt;
      key_down = vecs[i].mask;
      n = 0;
      while (!key_valid && n < 40) begin @(posedge clk); #1; n++; end
      check("press_latency_ok", (key_valid && n <= 27), 1'b1);
      check("key_code", key_code, vecs[i].code);
      check("key_held_set", key_held, 1'b1);
      bad = 0;
      for (int k = 0; k < vecs[i].hold; k++) begin
        @(posedge clk);
        #1;
        if (shift_col !== vecs[i].col) bad++;
      end
      check("col_frozen_bad_cycles", bad, 0);
      check("pulses_per_press", pulse_cnt - p0, 1);
      key_down = '0;
      n = 0;
      while (key_held && n < 20) begin @(posedge clk); #1; n++; end
      check("release_latency_ok", (!key_held && n >= 7 && n <= 10), 1'b1);
      check("col_after_release", shift_col, vecs[i].nxt);
      check("code_kept", key_code, vecs[i].code);
    end

    // Bounce: c0/r0 low at the pins for one cycle, seen by exactly one sample point.
    p0 = pulse_cnt;
    wait_col(4'b0111, n);
    check("bounce_wait_c0", shift_col, 4'b0111);
    @(posedge clk); #1;
    key_down = 16'h0001;
    @(posedge clk); #1;
    key_down = '0;
    repeat (3) @(posedge clk);
    #1;
    check("bounce_col_frozen", shift_col, 4'b0111);
    for (int i = 0; i < 4; i++) begin
      wait_change(n);
      check("bounce_rotation", shift_col, rot[i]);
    end
    check("bounce_no_pulse", pulse_cnt - p0, 0);

    // Reset while debouncing c0/r0.
    p0 = pulse_cnt;
    wait_col(4'b0111, n);
    check("rst_wait_c0", shift_col, 4'b0111);
    key_down = 16'h0001;
    repeat (5) @(posedge clk);
    #1;
    check("dbc_col_frozen", shift_col, 4'b0111);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    key_down = '0;
    check("mid_rst_shift_col", shift_col, 4'b0111);
    check("mid_rst_key_held", key_held, 1'b0);
    check("mid_rst_key_code", key_code, 4'h0);
    check("mid_rst_key_valid", key_valid, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_dwell", shift_col, 4'b0111);
    @(posedge clk);
    #1;
    check("mid_rst_adv", shift_col, 4'b1011);
    repeat (30) @(posedge clk);
    #1;
    check("mid_rst_no_pulse", pulse_cnt - p0, 0);

    check("onehot_bad_cycles", onehot_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
